hazard_control: RTL and testbench

- Pipeline interlock controller for the 5-stage MIPS core; sits beside decode, directly downstream of ForwardingUnit.
- Consumes ForwardingUnit's branch/JR `stall` and adds the hazards forwarding cannot cover: load-use in EXE and multi-cycle memory/fetch waits.
- Drives PC and pipeline-register enables and bubble injection.
- Tracks stall episodes in a small FSM with a timeout check on branch/JR waits.

---
 rtl/hazard_control_pkg.sv | 16 +
 rtl/hazard_control_wait_timer.sv | 34 +++
 rtl/hazard_control.sv | 136 +++++++++++++
 tb/tb_hazard_control.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline interlock controller.
// Optional statistics counters are enabled with HAZARD_STATS_EN (off by default).
package hazard_control_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HZ_RUN      = 2'd0,
        HZ_LD_STALL = 2'd1,
        HZ_BR_WAIT  = 2'd2,
        HZ_MEM_WAIT = 2'd3
    } hz_state_e;

endpackage

// File: rtl/hazard_control_wait_timer.sv
// Wait-episode timer: saturating counter plus sticky timeout flag.
module hazard_wait_timer
    import hazard_control_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              hold,
    input  logic              chk,
    input  logic [WAIT_W-1:0] limit,
    output logic              err
);

    logic [WAIT_W-1:0] count;

    // Count while the FSM stays in a wait state; latch error on limit hit
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (hold) begin
                if (count != '1) begin
                    count <= count + WAIT_W'(1);
                end
            end else begin
                count <= '0;
            end
            if (chk && (count == limit)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline interlock controller: load-use, branch/JR wait, memory and fetch stalls.
// Define HAZARD_STATS_EN to add stall/bubble/load-use statistics counters.
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int unsigned BR_MAX_WAIT  = 3,
    parameter int unsigned MEM_MAX_WAIT = 255
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned CNT_W        = 32
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EXE_load,
    input  logic [REG_W-1:0] EXE_WriteReg,
    input  logic             FU_stall,
    input  logic             MEM_busy,
    input  logic             IF_busy,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEXE_bubble,
    output logic             EXEMEM_write,
    output logic             MEMWB_bubble,
    output logic [1:0]       hz_state,
    output logic             hz_error
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] load_use_count
`endif
);

    hz_state_e         state;
    hz_state_e         state_nxt;
    logic              load_use;
    logic              stay_wait;
    logic              timeout_chk;
    logic [WAIT_W-1:0] wait_limit;

    // Dependent decode instruction needs the value the EXE load has not fetched yet
    assign load_use = EXE_load && (EXE_WriteReg != '0) &&
                      ((EXE_WriteReg == ID_rs) || (ID_uses_rt && (EXE_WriteReg == ID_rt)));

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= HZ_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Hazard arbitration: MEM_busy > load_use > FU_stall > IF_busy
    always_comb begin
        state_nxt    = HZ_RUN;
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEXE_bubble = 1'b0;
        EXEMEM_write = 1'b1;
        MEMWB_bubble = 1'b0;
        if (MEM_busy) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            EXEMEM_write = 1'b0;
            MEMWB_bubble = 1'b1;
            state_nxt    = HZ_MEM_WAIT;
        end else if (load_use && (state != HZ_LD_STALL)) begin
            // In LD_STALL the EXE slot already holds the bubble, so no second one
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEXE_bubble = 1'b1;
            state_nxt    = HZ_LD_STALL;
        end else if (FU_stall) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEXE_bubble = 1'b1;
            state_nxt    = HZ_BR_WAIT;
        end else if (IF_busy) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEXE_bubble = 1'b1;
        end
        if (!RESET) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            EXEMEM_write = 1'b0;
            IDEXE_bubble = 1'b1;
            MEMWB_bubble = 1'b1;
            state_nxt    = HZ_RUN;
        end
    end

    // Timer controls: count while staying in a wait state, limit chosen by state
    assign stay_wait   = (state_nxt == state) &&
                         ((state == HZ_BR_WAIT) || (state == HZ_MEM_WAIT));
    assign timeout_chk = ((state == HZ_BR_WAIT) && FU_stall) ||
                         ((state == HZ_MEM_WAIT) && MEM_busy);
    assign wait_limit  = (state == HZ_MEM_WAIT) ? WAIT_W'(MEM_MAX_WAIT) : WAIT_W'(BR_MAX_WAIT);
    assign hz_state    = state;

    hazard_wait_timer u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .hold  (stay_wait),
        .chk   (timeout_chk),
        .limit (wait_limit),
        .err   (hz_error)
    );

`ifdef HAZARD_STATS_EN
    // Free-running statistics counters, wrap on overflow
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stall_cycles   <= '0;
            bubble_count   <= '0;
            load_use_count <= '0;
        end else begin
            if (!PC_write) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (IDEXE_bubble) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
            if (load_use) begin
                load_use_count <= load_use_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed steps plus random traffic
// compared against an episode-based reference model.
module tb_hazard_control;

    localparam int BR_MAX  = 3;
    localparam int MEM_MAX = 255;
`ifdef HAZARD_STATS_EN
    localparam int CNT_W   = 32;
`endif

    // Which hazard the controller acts on in a cycle
    localparam int K_NONE = 0;
    localparam int K_IF   = 1;
    localparam int K_FU   = 2;
    localparam int K_LU   = 3;
    localparam int K_MEM  = 4;
    localparam int K_RST  = 5;

    logic       CLK;
    logic       RESET;
    logic [4:0] ID_rs, ID_rt, EXE_WriteReg;
    logic       ID_uses_rt, EXE_load, FU_stall, MEM_busy, IF_busy;
    logic       PC_write, IFID_write, IDEXE_bubble, EXEMEM_write, MEMWB_bubble;
    logic [1:0] hz_state;
    logic       hz_error;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles, bubble_count, load_use_count;
    int unsigned      m_stall, m_bubble, m_lu;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: last acted hazard, how many consecutive cycles it lasted, error
    int prev_kind = K_NONE;
    int streak    = 0;
    bit err_m     = 1'b0;

    hazard_control #(
        .BR_MAX_WAIT  (BR_MAX),
        .MEM_MAX_WAIT (MEM_MAX)
`ifdef HAZARD_STATS_EN
        ,
        .CNT_W        (CNT_W)
`endif
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_uses_rt   (ID_uses_rt),
        .EXE_load     (EXE_load),
        .EXE_WriteReg (EXE_WriteReg),
        .FU_stall     (FU_stall),
        .MEM_busy     (MEM_busy),
        .IF_busy      (IF_busy),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .IDEXE_bubble (IDEXE_bubble),
        .EXEMEM_write (EXEMEM_write),
        .MEMWB_bubble (MEMWB_bubble),
        .hz_state     (hz_state),
        .hz_error     (hz_error)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .bubble_count   (bubble_count),
        .load_use_count (load_use_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urt, input bit ld,
                          input int wr, input bit fu, input bit mem, input bit ifb);
        ID_rs        = 5'(rs);
        ID_rt        = 5'(rt);
        ID_uses_rt   = urt;
        EXE_load     = ld;
        EXE_WriteReg = 5'(wr);
        FU_stall     = fu;
        MEM_busy     = mem;
        IF_busy      = ifb;
    endtask

    task automatic idle();
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: check outputs at negedge against the model, then advance the model
    task automatic cycle();
        bit         lu;
        int         kind;
        int         wait_cnt;
        logic [4:0] exp_out;
        logic [1:0] exp_state;
        @(negedge CLK);
        lu = EXE_load && (EXE_WriteReg != 0) &&
             ((EXE_WriteReg == ID_rs) || (ID_uses_rt && (EXE_WriteReg == ID_rt)));
        if (!RESET)                          kind = K_RST;
        else if (MEM_busy)                   kind = K_MEM;
        else if (lu && prev_kind != K_LU)    kind = K_LU;
        else if (FU_stall)                   kind = K_FU;
        else if (IF_busy)                    kind = K_IF;
        else                                 kind = K_NONE;
        // {PC_write, IFID_write, IDEXE_bubble, EXEMEM_write, MEMWB_bubble}
        case (kind)
            K_RST:               exp_out = 5'b00101;
            K_MEM:               exp_out = 5'b00001;
            K_LU, K_FU, K_IF:    exp_out = 5'b00110;
            default:             exp_out = 5'b11010;
        endcase
        case (prev_kind)
            K_LU:    exp_state = 2'd1;
            K_FU:    exp_state = 2'd2;
            K_MEM:   exp_state = 2'd3;
            default: exp_state = 2'd0;
        endcase
        chk("enables", {PC_write, IFID_write, IDEXE_bubble, EXEMEM_write, MEMWB_bubble}, exp_out);
        chk("hz_state", hz_state, exp_state);
        chk("hz_error", hz_error, err_m);
`ifdef HAZARD_STATS_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("bubble_count", bubble_count, m_bubble);
        chk("load_use_count", load_use_count, m_lu);
`endif
        if (kind == K_RST) begin
            prev_kind = K_NONE;
            streak    = 0;
            err_m     = 1'b0;
`ifdef HAZARD_STATS_EN
            m_stall = 0; m_bubble = 0; m_lu = 0;
`endif
        end else begin
            wait_cnt = (streak - 1 > 255) ? 255 : streak - 1;
            if (prev_kind == K_FU && FU_stall && wait_cnt == BR_MAX)   err_m = 1'b1;
            if (prev_kind == K_MEM && MEM_busy && wait_cnt == MEM_MAX) err_m = 1'b1;
            if (kind == prev_kind) streak++;
            else                   streak = 1;
            prev_kind = kind;
`ifdef HAZARD_STATS_EN
            if (!exp_out[4]) m_stall++;
            if (exp_out[2])  m_bubble++;
            if (lu)          m_lu++;
`endif
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int fu_hold;
    int mem_hold;

    initial begin
        RESET = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        run(2);                                     // forced outputs under reset
        RESET = 1'b1;
        idle(); run(1);

        // load-use on rs: single bubble, then dependent advances
        set_in(5, 2, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0); run(1);
        set_in(5, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0); run(1);
        idle(); run(1);
        // load still visible in LD_STALL is not re-evaluated
        set_in(5, 2, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0); run(2);
        idle(); run(1);
        // rt dependency only when rt is read
        set_in(7, 9, 1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0); run(1);
        idle(); run(1);
        set_in(7, 9, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0); run(1);
        // zero register exemption
        set_in(0, 3, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0); run(1);
        idle(); run(1);

        // branch waits: below, at and past the limit
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); run(3);
        idle(); run(2);
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); run(4);
        idle(); run(1);
        chk("fu4_no_err", hz_error, 1'b0);
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); run(5);
        chk("fu5_err_set", hz_error, 1'b1);
        idle(); run(3);
        chk("err_sticky", hz_error, 1'b1);
        RESET = 1'b0; run(1);
        RESET = 1'b1; idle(); run(1);
        chk("err_cleared", hz_error, 1'b0);

        // MEM_busy beats load_use; bubble issues on release
        set_in(4, 1, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0); run(2);
        set_in(4, 1, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0); run(1);
        set_in(4, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1); run(1);
        idle(); run(1);
        // MEM_busy interrupting a branch wait
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); run(2);
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0); run(2);
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); run(1);
        idle(); run(1);

        // memory wait just below and at the timeout
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0); run(256);
        idle(); run(1);
        chk("mem256_no_err", hz_error, 1'b0);
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0); run(257);
        idle(); run(1);
        chk("mem257_err", hz_error, 1'b1);

        // reset in the middle of a memory wait
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0); run(3);
        RESET = 1'b0; run(1);
        RESET = 1'b1; idle(); run(1);
        chk("rst_state", hz_state, 2'd0);
        chk("rst_err", hz_error, 1'b0);

        // random traffic with bursty branch and memory waits
        fu_hold  = 0;
        mem_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (fu_hold == 0 && $urandom_range(0, 7) == 0)  fu_hold  = $urandom_range(1, 7);
            if (mem_hold == 0 && $urandom_range(0, 15) == 0) mem_hold = $urandom_range(1, 5);
            RESET        = ($urandom_range(0, 199) != 0);
            ID_rs        = 5'($urandom_range(0, 3));
            ID_rt        = 5'($urandom_range(0, 3));
            ID_uses_rt   = 1'($urandom_range(0, 1));
            EXE_load     = ($urandom_range(0, 2) == 0);
            EXE_WriteReg = 5'($urandom_range(0, 3));
            FU_stall     = (fu_hold != 0);
            MEM_busy     = (mem_hold != 0);
            IF_busy      = ($urandom_range(0, 5) == 0);
            if (fu_hold != 0)  fu_hold--;
            if (mem_hold != 0) mem_hold--;
            cycle();
        end

`ifdef HAZARD_STATS_EN
        // three load-use stalls plus a two-cycle branch wait
        RESET = 1'b0; idle(); run(1);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(6, 2, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0); run(1);
            idle(); run(1);
        end
        set_in(1, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); run(2);
        idle(); run(1);
        chk("stats_lu", load_use_count, 3);
        chk("stats_bubble", bubble_count, 5);
        chk("stats_stall", stall_cycles, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
